// File: rtl/if_prefetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package if_prefetch_pkg;

    localparam logic [31:0] INST_NOP         = 32'h0000_0013;
    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [31:0] addr;
        logic [31:0] inst;
    } fetch_entry_t;

    function automatic logic [31:0] word_align(input logic [31:0] a);
        return {a[31:2], 2'b00};
    endfunction

endpackage

// File: rtl/if_prefetch_if.sv
// Fetch-unit bus bundle: ROM read port on one side, decode handshake on the other.
interface if_prefetch_if;

    logic        rom_req_o;
    logic [31:0] rom_addr_o;
    logic [31:0] rom_data_i;
    logic [31:0] inst_o;
    logic [31:0] inst_addr_o;
    logic        inst_valid_o;
    logic        hold_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;

    modport master (
        output rom_req_o, rom_addr_o, inst_o, inst_addr_o, inst_valid_o,
        input  rom_data_i, hold_i, jump_en_i, jump_addr_i
    );

    modport slave (
        input  rom_req_o, rom_addr_o, inst_o, inst_addr_o, inst_valid_o,
        output rom_data_i, hold_i, jump_en_i, jump_addr_i
    );

endinterface

// File: rtl/if_prefetch_fifo.sv
// DEPTH x {addr, inst} synchronous FIFO; flush beats push and pop.
module if_fifo
    import if_prefetch_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     flush,
    input  fetch_entry_t             din,
    output fetch_entry_t             dout,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    fetch_entry_t   mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic           do_push;
    logic           do_pop;

    assign empty   = (count == '0);
    assign full    = (count == (AW+1)'(DEPTH));
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && !flush && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/if_prefetch.sv
// Instruction-fetch front end: sequential PC, credit-limited ROM issue,
// one-cycle ROM response capture into a small FIFO, redirect flush.
module if_prefetch
    import if_prefetch_pkg::*;
#(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    if_prefetch_if.master     bus
);

    localparam int CW = $clog2(DEPTH) + 1;

    logic [31:0]   pc;
    logic [31:0]   inflight_addr;
    logic          inflight;
    logic [31:0]   fetch_addr;
    logic [CW:0]   credits;
    logic          issue;
    logic          push;
    logic          pop;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;
    fetch_entry_t  head;
    fetch_entry_t  resp;

    always_comb begin
        fetch_addr = bus.jump_en_i ? word_align(bus.jump_addr_i) : pc;
        credits    = {1'b0, count} + (CW+1)'(inflight);
        issue      = !rst && (bus.jump_en_i || (!full && credits < (CW+1)'(DEPTH)));
        // A response landing in the redirect cycle belongs to the old stream;
        // killing it here is what the separate kill flag would otherwise record.
        push       = inflight && !bus.jump_en_i;
        pop        = !empty && !bus.hold_i && !bus.jump_en_i;
        resp       = '{addr: inflight_addr, inst: bus.rom_data_i};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            pc            <= RESET_PC;
            inflight      <= 1'b0;
            inflight_addr <= '0;
        end else begin
            inflight <= issue;
            if (issue) begin
                pc            <= fetch_addr + 32'd4;
                inflight_addr <= fetch_addr;
            end
        end
    end

    if_fifo #(.DEPTH(DEPTH)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .flush (bus.jump_en_i),
        .din   (resp),
        .dout  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign bus.rom_req_o    = issue;
    assign bus.rom_addr_o   = fetch_addr;
    assign bus.inst_valid_o = !empty;
    assign bus.inst_o       = empty ? INST_NOP : head.inst;
    assign bus.inst_addr_o  = empty ? 32'h0 : head.addr;

endmodule

// File: tb/tb_if_prefetch.sv
// Directed + randomized bench for if_prefetch against a stream-level model.
module tb_if_prefetch;

    localparam int          DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;
    localparam logic [31:0] RPC2  = 32'hFFFF_FFF8;
    localparam logic [31:0] NOP   = 32'h0000_0013;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    if_prefetch_if ifc();
    if_prefetch_if ifc2();

    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC))  dut  (.clk(clk), .rst(rst), .bus(ifc.master));
    if_prefetch #(.DEPTH(DEPTH), .RESET_PC(RPC2)) dut2 (.clk(clk), .rst(rst), .bus(ifc2.master));

    // ROM word at byte address a holds 0x100 + word index
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return 32'h100 + (a >> 2);
    endfunction

    always @(posedge clk) begin
        ifc.rom_data_i  <= ifc.rom_req_o  ? rom_word(ifc.rom_addr_o)  : $urandom;
        ifc2.rom_data_i <= ifc2.rom_req_o ? rom_word(ifc2.rom_addr_o) : $urandom;
    end

    int checks = 0;
    int errors = 0;

    // stream-level model state
    int          occ;       // fetched but not yet consumed (buffered + in flight)
    int          nreq;      // requests since last reset
    logic [31:0] next_exp;  // next address decode must receive
    logic [31:0] fpc;       // next sequential fetch address
    logic [31:0] next2;
    bit          held;
    logic [31:0] held_addr, held_inst;

    logic        o_vld, o_req, o2_vld;
    logic [31:0] o_addr, o_inst, o_raddr, o2_addr, o2_inst;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick(input bit r, input bit h, input bit j, input logic [31:0] ja);
        logic [31:0] tgt;
        bit          req_exp, popped;
        tgt = {ja[31:2], 2'b00};
        rst = r;
        ifc.hold_i = h; ifc.jump_en_i = j; ifc.jump_addr_i = ja;
        @(negedge clk);
        o_vld = ifc.inst_valid_o;  o_addr = ifc.inst_addr_o; o_inst = ifc.inst_o;
        o_req = ifc.rom_req_o;     o_raddr = ifc.rom_addr_o;
        o2_vld = ifc2.inst_valid_o; o2_addr = ifc2.inst_addr_o; o2_inst = ifc2.inst_o;
        if (r) begin
            chk("req_in_reset", o_req, 1'b0);
            occ = 0; nreq = 0; next_exp = RPC; fpc = RPC; next2 = RPC2;
        end else begin
            req_exp = j || (occ < DEPTH);
            chk("req", o_req, req_exp);
            if (o_req) chk("req_addr", o_raddr, j ? tgt : fpc);
            if (held) begin
                chk("hold_addr", o_addr, held_addr);
                chk("hold_inst", o_inst, held_inst);
            end
            if (!o_vld) begin
                chk("idle_inst", o_inst, NOP);
                chk("idle_addr", o_addr, 32'h0);
            end
            popped = o_vld && !h && !j;
            if (popped) begin
                chk("pop_addr", o_addr, next_exp);
                chk("pop_inst", o_inst, rom_word(next_exp));
                next_exp = next_exp + 32'd4;
            end
            if (o_req) begin
                nreq++;
                fpc = (j ? tgt : fpc) + 32'd4;
            end
            if (j) begin
                occ = 1;
                next_exp = tgt;
            end else begin
                occ = occ + int'(o_req) - int'(popped);
            end
            if (o2_vld) begin
                chk("wrap_addr", o2_addr, next2);
                chk("wrap_inst", o2_inst, rom_word(next2));
                next2 = next2 + 32'd4;
            end
        end
        held = !r && o_vld && h && !j;
        held_addr = o_addr; held_inst = o_inst;
        @(posedge clk); #1;
    endtask

    initial begin
        ifc.hold_i = 1'b0; ifc.jump_en_i = 1'b0; ifc.jump_addr_i = '0;
        ifc2.hold_i = 1'b0; ifc2.jump_en_i = 1'b0; ifc2.jump_addr_i = '0;
        held = 1'b0;

        // reset release and cycle-2 latency, plus wrap at top of address space
        tick(1, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("c0_req", o_req, 1'b1);
        chk("c0_raddr", o_raddr, RPC);
        chk("c0_vld", o_vld, 1'b0);
        chk("c0_inst", o_inst, NOP);
        tick(0, 0, 0, 0);
        chk("c1_vld", o_vld, 1'b0);
        tick(0, 0, 0, 0);
        chk("c2_vld", o_vld, 1'b1);
        chk("c2_addr", o_addr, RPC);
        chk("c2_inst", o_inst, 32'h100);
        chk("w2_addr", o2_addr, 32'hFFFF_FFF8);
        tick(0, 0, 0, 0);
        chk("c3_addr", o_addr, 32'h4);
        chk("w3_addr", o2_addr, 32'hFFFF_FFFC);
        tick(0, 0, 0, 0);
        chk("c4_addr", o_addr, 32'h8);
        chk("w4_addr", o2_addr, 32'h0);
        chk("w4_inst", o2_inst, 32'h100);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);

        // hold from first valid: FIFO fills to DEPTH then fetch stops
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 9; i++) begin
            tick(0, 1, 0, 0);
            chk("hold_head", o_addr, RPC);
        end
        chk("hold_nreq", nreq, DEPTH);
        chk("hold_req_off", o_req, 1'b0);
        tick(0, 0, 0, 0);
        for (int i = 1; i <= 3; i++) begin
            tick(0, 0, 0, 0);
            chk("rel_vld", o_vld, 1'b1);
            chk("rel_addr", o_addr, 32'(4 * i));
        end

        // redirect during streaming
        for (int i = 0; i < 3; i++) tick(0, 0, 0, 0);
        tick(0, 0, 1, 32'h203);
        chk("jmp_raddr", o_raddr, 32'h200);
        tick(0, 0, 0, 0);
        chk("j1_vld", o_vld, 1'b0);
        tick(0, 0, 0, 0);
        chk("j2_vld", o_vld, 1'b1);
        chk("j2_addr", o_addr, 32'h200);
        chk("j2_inst", o_inst, 32'h180);
        tick(0, 0, 0, 0);
        chk("j3_addr", o_addr, 32'h204);

        // redirect while full and held
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        tick(0, 0, 0, 0);
        for (int i = 0; i < 6; i++) tick(0, 1, 0, 0);
        chk("full_req_off", o_req, 1'b0);
        tick(0, 1, 1, 32'h40);
        chk("fj_req", o_req, 1'b1);
        tick(0, 1, 0, 0);
        chk("fj1_vld", o_vld, 1'b0);
        tick(0, 1, 0, 0);
        chk("fj2_vld", o_vld, 1'b1);
        chk("fj2_addr", o_addr, 32'h40);
        tick(0, 1, 0, 0);
        chk("fj3_addr", o_addr, 32'h40);
        tick(0, 0, 0, 0);

        // randomized hold / redirect / occasional reset traffic
        for (int i = 0; i < 1500; i++) begin
            tick($urandom_range(0, 99) < 1,
                 $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 6,
                 $urandom);
        end

        // one-cycle reset mid-stream: no stale entries, normal restart latency
        tick(0, 0, 0, 0);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);
        tick(1, 0, 0, 0);
        tick(0, 0, 0, 0);
        chk("rr0_vld", o_vld, 1'b0);
        chk("rr0_raddr", o_raddr, RPC);
        tick(0, 0, 0, 0);
        chk("rr1_vld", o_vld, 1'b0);
        tick(0, 0, 0, 0);
        chk("rr2_vld", o_vld, 1'b1);
        chk("rr2_addr", o_addr, RPC);
        for (int i = 0; i < 4; i++) tick(0, 0, 0, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
